adder_accumulator: RTL and testbench

Downstream consumer of the 4-bit adder stage. Each cycle it takes one adder result (4-bit `Sum` plus the `Overflow` carry), accumulates a fixed-size batch of results into a wider saturating total, counts how many results carried, and presents the batch result on a valid/ready output. While a finished batch is waiting to be taken, the block back-pressures the adder side through `In_Ready`.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_accumulator_sat_add.sv | 21 ++
 rtl/adder_accumulator.sv | 95 +++++++++
 tb/tb_adder_accumulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder result datapath.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package adder_pkg;

    localparam int SUM_W = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // The adder carry is the fifth bit of the result, not a separate flag.
    function automatic logic [SUM_W:0] sample_of(input logic ovf, input logic [SUM_W-1:0] sum);
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/adder_accumulator_sat_add.sv
// Unsigned adder that clips to all-ones instead of wrapping.
// Combinational, zero latency.
// No flow control; caller qualifies the result.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         clip
);

    logic [W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b};
        clip = raw[W];
        sum  = raw[W] ? {W{1'b1}} : raw[W-1:0];
    end

endmodule

// File: rtl/adder_accumulator.sv
// Sums a fixed-size batch of adder results into a saturating total plus a carry count.
// One transfer per cycle; result valid the cycle after the last transfer of a batch.
// In_Ready is low while a finished batch waits for Out_Ready (or Clear).
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 8,
    parameter int CNT_W     = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    input  logic [SUM_W-1:0] Sum,
    input  logic             Overflow,
    output logic             In_Ready,
    input  logic             Clear,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [ACC_W-1:0] Acc_Out,
    output logic [CNT_W-1:0] Ovf_Cnt,
    output logic             Acc_Sat
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] sample;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             clip;
    logic             xfer;
    logic             drain;

    assign sample = ACC_W'(sample_of(Overflow, Sum));
    assign xfer   = In_Valid && (state == ACCUM);
    assign drain  = (state == HOLD) && Out_Ready;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a    (acc),
        .b    (sample),
        .sum  (acc_nxt),
        .clip (clip)
    );

    always_comb begin
        state_nxt = state;
        if (Clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (xfer && (cnt == LAST)) state_nxt = HOLD;
                HOLD:    if (Out_Ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            ovf_cnt <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
        end else begin
            state <= state_nxt;
            // Clear wins over a same-cycle transfer so an aborted batch leaves nothing behind.
            if (Clear || drain) begin
                acc     <= '0;
                ovf_cnt <= '0;
                cnt     <= '0;
                sat     <= 1'b0;
            end else if (xfer) begin
                acc     <= acc_nxt;
                ovf_cnt <= ovf_cnt + CNT_W'(Overflow);
                cnt     <= cnt + CNT_W'(1);
                sat     <= sat | clip;
            end
        end
    end

    assign In_Ready  = (state == ACCUM);
    assign Out_Valid = (state == HOLD);
    assign Acc_Out   = acc;
    assign Ovf_Cnt   = ovf_cnt;
    assign Acc_Sat   = sat;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator: default-width and 7-bit-accumulator instances share stimulus.
module tb_adder_accumulator;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       In_Valid = 1'b0;
    logic [3:0] Sum = 4'd0;
    logic       Overflow = 1'b0;
    logic       Clear = 1'b0;
    logic       Out_Ready = 1'b0;

    logic       In_Ready, Out_Valid, Acc_Sat;
    logic [7:0] Acc_Out;
    logic [3:0] Ovf_Cnt;

    logic       in_ready7, out_valid7, sat7;
    logic [6:0] acc7;
    logic [3:0] ovf7;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    adder_accumulator dut (
        .Clk (Clk), .Rst_n (Rst_n), .In_Valid (In_Valid), .Sum (Sum), .Overflow (Overflow),
        .In_Ready (In_Ready), .Clear (Clear), .Out_Valid (Out_Valid), .Out_Ready (Out_Ready),
        .Acc_Out (Acc_Out), .Ovf_Cnt (Ovf_Cnt), .Acc_Sat (Acc_Sat)
    );

    adder_accumulator #(.N_SAMPLES(8), .ACC_W(7), .CNT_W(4)) dut7 (
        .Clk (Clk), .Rst_n (Rst_n), .In_Valid (In_Valid), .Sum (Sum), .Overflow (Overflow),
        .In_Ready (in_ready7), .Clear (Clear), .Out_Valid (out_valid7), .Out_Ready (Out_Ready),
        .Acc_Out (acc7), .Ovf_Cnt (ovf7), .Acc_Sat (sat7)
    );

    // Offer n back-to-back transfers starting on the next clock.
    task automatic send(input int n, input logic [3:0] s, input logic o);
        @(negedge Clk);
        In_Valid = 1'b1; Sum = s; Overflow = o;
        repeat (n) @(posedge Clk);
        #1 In_Valid = 1'b0;
    endtask

    task automatic accept();
        @(negedge Clk);
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1 Out_Ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", In_Ready); end
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", Out_Valid); end
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL rst_acc got=%0d exp=0", Acc_Out); end
        checks++; if (Ovf_Cnt !== 4'd0) begin errors++; $display("FAIL rst_ovf got=%0d exp=0", Ovf_Cnt); end
        checks++; if (Acc_Sat !== 1'b0) begin errors++; $display("FAIL rst_sat got=%b exp=0", Acc_Sat); end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        send(7, 4'd3, 1'b0);
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL dflt_early_valid got=%b exp=0", Out_Valid); end
        checks++; if (Acc_Out !== 8'd21) begin errors++; $display("FAIL dflt_partial_acc got=%0d exp=21", Acc_Out); end
        send(1, 4'd3, 1'b0);
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL dflt_valid got=%b exp=1", Out_Valid); end
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL dflt_in_ready got=%b exp=0", In_Ready); end
        checks++; if (Acc_Out !== 8'd24) begin errors++; $display("FAIL dflt_acc got=%0d exp=24", Acc_Out); end
        checks++; if (Ovf_Cnt !== 4'd0) begin errors++; $display("FAIL dflt_ovf got=%0d exp=0", Ovf_Cnt); end
        checks++; if (Acc_Sat !== 1'b0) begin errors++; $display("FAIL dflt_sat got=%b exp=0", Acc_Sat); end
        accept();
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL dflt_drain_valid got=%b exp=0", Out_Valid); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL dflt_drain_ready got=%b exp=1", In_Ready); end
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL dflt_drain_acc got=%0d exp=0", Acc_Out); end
    endtask

    task automatic test_carry();
        send(8, 4'd15, 1'b1);
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL carry_valid got=%b exp=1", Out_Valid); end
        checks++; if (Acc_Out !== 8'd248) begin errors++; $display("FAIL carry_acc got=%0d exp=248", Acc_Out); end
        checks++; if (Ovf_Cnt !== 4'd8) begin errors++; $display("FAIL carry_ovf got=%0d exp=8", Ovf_Cnt); end
        checks++; if (Acc_Sat !== 1'b0) begin errors++; $display("FAIL carry_sat got=%b exp=0", Acc_Sat); end
        accept();
    endtask

    task automatic test_saturation();
        send(8, 4'd15, 1'b1);
        @(negedge Clk);
        checks++; if (out_valid7 !== 1'b1) begin errors++; $display("FAIL sat_valid got=%b exp=1", out_valid7); end
        checks++; if (acc7 !== 7'd127) begin errors++; $display("FAIL sat_acc got=%0d exp=127", acc7); end
        checks++; if (sat7 !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", sat7); end
        checks++; if (ovf7 !== 4'd8) begin errors++; $display("FAIL sat_ovf got=%0d exp=8", ovf7); end
        repeat (3) @(negedge Clk);
        checks++; if (sat7 !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", sat7); end
        checks++; if (acc7 !== 7'd127) begin errors++; $display("FAIL sat_hold_acc got=%0d exp=127", acc7); end
        accept();
        @(negedge Clk);
        checks++; if (sat7 !== 1'b0) begin errors++; $display("FAIL sat_cleared got=%b exp=0", sat7); end
    endtask

    task automatic test_back_pressure();
        @(negedge Clk);
        In_Valid = 1'b1; Sum = 4'd2; Overflow = 1'b0;
        repeat (8) @(posedge Clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, In_Ready); end
            checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, Out_Valid); end
            checks++; if (Acc_Out !== 8'd16) begin errors++; $display("FAIL bp_acc cyc=%0d got=%0d exp=16", i, Acc_Out); end
        end
        Out_Ready = 1'b1; Sum = 4'd5;
        @(posedge Clk);
        #1 Out_Ready = 1'b0;
        @(negedge Clk);
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got=%b exp=1", In_Ready); end
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL bp_restart_acc got=%0d exp=0", Acc_Out); end
        @(negedge Clk);
        In_Valid = 1'b0;
        checks++; if (Acc_Out !== 8'd5) begin errors++; $display("FAIL bp_first_sample got=%0d exp=5", Acc_Out); end
        Clear = 1'b1;
        @(posedge Clk);
        #1 Clear = 1'b0;
    endtask

    task automatic test_abort();
        send(3, 4'd1, 1'b0);
        @(negedge Clk);
        checks++; if (Acc_Out !== 8'd3) begin errors++; $display("FAIL abort_partial got=%0d exp=3", Acc_Out); end
        Clear = 1'b1; In_Valid = 1'b1; Sum = 4'd7;
        @(posedge Clk);
        #1 Clear = 1'b0; In_Valid = 1'b0;
        @(negedge Clk);
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL abort_acc got=%0d exp=0", Acc_Out); end
        send(8, 4'd1, 1'b0);
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL abort_refill_valid got=%b exp=1", Out_Valid); end
        checks++; if (Acc_Out !== 8'd8) begin errors++; $display("FAIL abort_refill_acc got=%0d exp=8", Acc_Out); end
        Clear = 1'b1;
        @(posedge Clk);
        #1 Clear = 1'b0;
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL abort_hold_valid got=%b exp=0", Out_Valid); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL abort_hold_ready got=%b exp=1", In_Ready); end
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL abort_hold_acc got=%0d exp=0", Acc_Out); end
    endtask

    task automatic test_reset_midbatch();
        send(4, 4'd3, 1'b1);
        @(negedge Clk);
        checks++; if (Acc_Out !== 8'd76) begin errors++; $display("FAIL mid_partial_acc got=%0d exp=76", Acc_Out); end
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL mid_rst_acc got=%0d exp=0", Acc_Out); end
        checks++; if (Ovf_Cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_ovf got=%0d exp=0", Ovf_Cnt); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", In_Ready); end
        @(negedge Clk);
        Rst_n = 1'b1;
        send(8, 4'd4, 1'b0);
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL mid_after_valid got=%b exp=1", Out_Valid); end
        checks++; if (Acc_Out !== 8'd32) begin errors++; $display("FAIL mid_after_acc got=%0d exp=32", Acc_Out); end
        checks++; if (Ovf_Cnt !== 4'd0) begin errors++; $display("FAIL mid_after_ovf got=%0d exp=0", Ovf_Cnt); end
        // Reset while a result is pending must also drop it.
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL hold_rst_valid got=%b exp=0", Out_Valid); end
        checks++; if (Acc_Out !== 8'd0) begin errors++; $display("FAIL hold_rst_acc got=%0d exp=0", Acc_Out); end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_defaults();
        test_carry();
        test_saturation();
        test_back_pressure();
        test_abort();
        test_reset_midbatch();
        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
